// File: rtl/dma_pkg.sv
// Shared definitions for the DMA copy engine slice.
// Contents: FSM state enum, default DATA_W/DEPTH/LEN_W, stall-counter width,
// and a helper that sizes the FIFO read/write pointers.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

  localparam int unsigned DMA_DATA_W  = 128;
  localparam int unsigned DMA_DEPTH   = 4;
  localparam int unsigned DMA_LEN_W   = 16;
  localparam int unsigned DMA_STALL_W = 32;

  // One extra pointer bit distinguishes full from empty when indices match.
  function automatic int unsigned dma_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dma_copy_engine_if.sv
// DMA port bundle between the copy engine and the DMA controller.
// master: engine side (drives dma_req, dma_read_ready, dma_write_valid/data).
// slave : DMA side (drives dma_resp, dma_read_valid/data, dma_write_ready).
interface dma_copy_engine_if
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W = DMA_DATA_W
) ();

  logic              dma_req;
  logic              dma_resp;
  logic              dma_read_valid;
  logic [DATA_W-1:0] dma_read_data;
  logic              dma_read_ready;
  logic              dma_write_valid;
  logic [DATA_W-1:0] dma_write_data;
  logic              dma_write_ready;

  modport master (
    output dma_req,
    input  dma_resp,
    input  dma_read_valid,
    input  dma_read_data,
    output dma_read_ready,
    output dma_write_valid,
    output dma_write_data,
    input  dma_write_ready
  );

  modport slave (
    input  dma_req,
    output dma_resp,
    output dma_read_valid,
    output dma_read_data,
    input  dma_read_ready,
    input  dma_write_valid,
    input  dma_write_data,
    output dma_write_ready
  );

endinterface

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO buffering read beats until the write side takes them.
// Ports: clk, rst_n (async, active-low), push_i/push_data_i, pop_i,
// flush_i (empties the FIFO, wins over push/pop), full_o, empty_o,
// count_o (occupancy), head_o (oldest entry).
// Pushes while full and pops while empty are ignored.
module dma_sync_fifo
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W = DMA_DATA_W,
  parameter int unsigned DEPTH  = DMA_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [dma_ptr_w(DEPTH)-1:0]   count_o,
  output logic [DATA_W-1:0]             head_o
);

  localparam int unsigned PW = dma_ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]     wr_ptr_d, rd_ptr_d;
  logic              do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (count_o == PW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/dma_copy_engine.sv
// DMA copy engine: after an accepted start, requests the DMA port, then copies
// xfer_len beats from the read stream to the write stream through a FIFO and
// reports completion with a one-cycle done pulse (aborted qualifies it).
// Ports: clk, rst_n (async, active-low), start, xfer_len, abort,
// busy, done, aborted, dma (dma_copy_engine_if.master: dma_req/dma_resp
// grant handshake, read stream in, write stream out).
// Optional: DMA_STALL_CNT_EN adds stall_cnt[31:0], a saturating count of
// XFER cycles where a write beat was offered but not accepted.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W = DMA_DATA_W,
  parameter int unsigned DEPTH  = DMA_DEPTH,
  parameter int unsigned LEN_W  = DMA_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LEN_W-1:0]       xfer_len,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
`ifdef DMA_STALL_CNT_EN
  output logic [DMA_STALL_W-1:0] stall_cnt,
`endif
  dma_copy_engine_if.master      dma
);

  localparam int unsigned PW = dma_ptr_w(DEPTH);

  dma_state_e       state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             busy_q, done_q, aborted_q, req_q;

  logic             in_xfer, start_ok;
  logic             rd_ready, wr_valid;
  logic             push, pop, flush;
  logic             fifo_full, fifo_empty;
  logic [PW-1:0]    fifo_count;
  logic [DATA_W-1:0] fifo_head;

  assign in_xfer  = (state_q == ST_XFER);
  assign start_ok = (state_q == ST_IDLE) && start;

  // Ready depends only on registered state, so dma_write_ready never reaches
  // dma_read_ready combinationally; a full FIFO refuses a push even if it pops.
  assign rd_ready = in_xfer && (fifo_count < PW'(DEPTH)) && (rd_cnt_q < len_q);
  assign wr_valid = in_xfer && !fifo_empty;
  assign push     = rd_ready && dma.dma_read_valid;
  assign pop      = wr_valid && dma.dma_write_ready;
  assign flush    = in_xfer && abort;

  assign dma.dma_req         = req_q;
  assign dma.dma_read_ready  = rd_ready;
  assign dma.dma_write_valid = wr_valid;
  assign dma.dma_write_data  = wr_valid ? fifo_head : '0;

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

  dma_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (dma.dma_read_data),
    .pop_i       (pop),
    .flush_i     (flush),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (start_ok) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (push) rd_cnt_d = rd_cnt_q + LEN_W'(1);
      if (pop)  wr_cnt_d = wr_cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q     <= xfer_len;
            aborted_q <= 1'b0;
            busy_q    <= 1'b1;
            if (xfer_len != '0) begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end else begin
              // Zero-length transfer completes without touching the DMA port.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (abort) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
            req_q     <= 1'b0;
          end else if (dma.dma_resp) begin
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Grant is not re-checked here: the transfer runs to completion.
          if (abort) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
            req_q     <= 1'b0;
          end else if (wr_cnt_d == len_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            req_q   <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The count-based ready above must agree with the FIFO's own full flag.
  assert property (@(posedge clk) disable iff (!rst_n) fifo_full |-> !push);

`ifdef DMA_STALL_CNT_EN
  logic [DMA_STALL_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (wr_valid && !dma.dma_write_ready && (stall_q != '1)) begin
      stall_q <= stall_q + DMA_STALL_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine. The source streams beat k as
// mkdata(k); every accepted start pushes the beats the engine must write
// onto a scoreboard queue, and a monitor pops and compares on each write
// handshake. Sampling happens 1 time unit before each rising edge.
module tb_dma_copy_engine;
  import dma_pkg::*;

  localparam int unsigned DW  = 128;
  localparam int unsigned DEP = 4;
  localparam int unsigned LW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] xfer_len;
  logic          abort;
  logic          busy, done, aborted;
`ifdef DMA_STALL_CNT_EN
  logic [31:0]   stall_cnt;
  int unsigned   stall_model = 0;
`endif

  dma_copy_engine_if #(.DATA_W(DW)) dma_bus ();

  dma_copy_engine #(
    .DATA_W (DW),
    .DEPTH  (DEP),
    .LEN_W  (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .xfer_len  (xfer_len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
`ifdef DMA_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .dma       (dma_bus)
  );

  always #5 clk = ~clk;

  int unsigned       n_checks = 0, n_pass = 0;
  int unsigned       src_idx = 0, rd_acc = 0, wr_seen = 0;
  int unsigned       done_cnt = 0, req_cnt = 0, cyc = 0;
  int unsigned       wr_cyc[$];
  logic [DW-1:0]     exp_q[$];
  bit                resp_en = 1'b1;

  function automatic logic [DW-1:0] mkdata(input int unsigned i);
    logic [31:0] w;
    w = i;
    return {w ^ 32'hA5A5_5A5A, w * 32'd3 + 32'd7, ~w, w + 32'd1};
  endfunction

  assign dma_bus.dma_read_data = mkdata(src_idx);

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // DMA grant: answers a pending request on the following half cycle.
  initial begin
    dma_bus.dma_resp = 1'b0;
    forever begin
      @(negedge clk);
      dma_bus.dma_resp = resp_en && dma_bus.dma_req;
    end
  end

  // Source: advances to the next beat after each accepted read.
  initial begin
    bit acc;
    forever begin
      @(negedge clk); #4;
      acc = rst_n && dma_bus.dma_read_valid && dma_bus.dma_read_ready;
      @(posedge clk); #1;
      if (acc) begin
        src_idx++;
        rd_acc++;
      end
    end
  end

  // Monitor: scoreboard compare on write handshakes, event counters.
  initial begin
    logic [DW-1:0] exp_w;
    forever begin
      @(negedge clk); #4;
      cyc++;
      if (rst_n) begin
        if (dma_bus.dma_write_valid && dma_bus.dma_write_ready) begin
          wr_seen++;
          wr_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL wdata: got %0h expected no write", dma_bus.dma_write_data);
          end else begin
            exp_w = exp_q.pop_front();
            chk("wdata", dma_bus.dma_write_data, exp_w);
          end
        end
        if (done) done_cnt++;
        if (dma_bus.dma_req) req_cnt++;
`ifdef DMA_STALL_CNT_EN
        if (busy && dma_bus.dma_req && dma_bus.dma_write_valid && !dma_bus.dma_write_ready)
          stall_model++;
`endif
      end
    end
  end

  initial begin
    #(200_000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; pulses start for one cycle.
  task automatic start_xfer(input int unsigned len, input bit expect_beats);
    start    = 1'b1;
    xfer_len = LW'(len);
    if (expect_beats)
      for (int unsigned i = 0; i < len; i++) exp_q.push_back(mkdata(src_idx + i));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned max, input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < max; i++) begin
      @(negedge clk);
      if (rnd) begin
        dma_bus.dma_read_valid  = 1'($urandom_range(0, 1));
        dma_bus.dma_write_ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL wait_done: got no done expected done within %0d cycles", max);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},    DW'(busy), '0);
    chk({tag, "_done"},    DW'(done), '0);
    chk({tag, "_aborted"}, DW'(aborted), '0);
    chk({tag, "_req"},     DW'(dma_bus.dma_req), '0);
    chk({tag, "_rready"},  DW'(dma_bus.dma_read_ready), '0);
    chk({tag, "_wvalid"},  DW'(dma_bus.dma_write_valid), '0);
    chk({tag, "_wdata"},   dma_bus.dma_write_data, '0);
  endtask

  initial begin
    int unsigned b_rd, b_wr, b_done, b_req, n;
`ifdef DMA_STALL_CNT_EN
    int unsigned b_stall;
`endif
    rst_n = 1'b0;
    start = 1'b0;
    xfer_len = '0;
    abort = 1'b0;
    dma_bus.dma_read_valid  = 1'b0;
    dma_bus.dma_write_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // len=4, both sides always ready.
    dma_bus.dma_read_valid = 1'b1;
    dma_bus.dma_write_ready = 1'b1;
    b_rd = rd_acc; b_wr = wr_seen; b_done = done_cnt;
    start_xfer(4, 1'b1);
    wait_done(50, 1'b0);
    chk("t1_aborted", DW'(aborted), '0);
    chk("t1_req_at_done", DW'(dma_bus.dma_req), '0);
    chk("t1_rready_at_done", DW'(dma_bus.dma_read_ready), '0);
    chk("t1_wvalid_at_done", DW'(dma_bus.dma_write_valid), '0);
    repeat (2) @(negedge clk);
    chk("t1_reads", DW'(rd_acc - b_rd), DW'(4));
    chk("t1_writes", DW'(wr_seen - b_wr), DW'(4));
    chk("t1_done_pulses", DW'(done_cnt - b_done), DW'(1));
    chk("t1_sb_empty", DW'(exp_q.size()), '0);
    n = wr_cyc.size();
    chk("t1_throughput", DW'(wr_cyc[n-1] - wr_cyc[n-4]), DW'(3));

    // len=8 with the write side stalled until the FIFO fills.
    dma_bus.dma_write_ready = 1'b0;
    b_rd = rd_acc; b_wr = wr_seen; b_done = done_cnt;
`ifdef DMA_STALL_CNT_EN
    b_stall = stall_model;
`endif
    start_xfer(8, 1'b1);
    repeat (12) @(negedge clk);
    chk("t2_reads_while_full", DW'(rd_acc - b_rd), DW'(4));
    chk("t2_rready_full", DW'(dma_bus.dma_read_ready), '0);
    chk("t2_wvalid_full", DW'(dma_bus.dma_write_valid), DW'(1));
    dma_bus.dma_write_ready = 1'b1;
    wait_done(50, 1'b0);
    repeat (2) @(negedge clk);
    chk("t2_reads", DW'(rd_acc - b_rd), DW'(8));
    chk("t2_writes", DW'(wr_seen - b_wr), DW'(8));
    chk("t2_sb_empty", DW'(exp_q.size()), '0);
`ifdef DMA_STALL_CNT_EN
    chk("t2_stall_cnt", DW'(stall_cnt), DW'(stall_model - b_stall));
`endif

    // len=0: done without any DMA activity.
    b_rd = rd_acc; b_wr = wr_seen; b_done = done_cnt; b_req = req_cnt;
    start_xfer(0, 1'b0);
    chk("t3_zero_done", DW'(done), DW'(1));
    chk("t3_zero_req", DW'(dma_bus.dma_req), '0);
    repeat (2) @(negedge clk);
    chk("t3_zero_done_pulses", DW'(done_cnt - b_done), DW'(1));
    chk("t3_zero_req_cycles", DW'(req_cnt - b_req), '0);
    chk("t3_zero_reads", DW'(rd_acc - b_rd), '0);
    chk("t3_zero_writes", DW'(wr_seen - b_wr), '0);

    // start pulsed during XFER must be ignored.
    dma_bus.dma_write_ready = 1'b0;
    b_rd = rd_acc; b_wr = wr_seen; b_done = done_cnt;
    start_xfer(3, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    xfer_len = LW'(7);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dma_bus.dma_write_ready = 1'b1;
    wait_done(50, 1'b0);
    repeat (2) @(negedge clk);
    chk("t3_ign_reads", DW'(rd_acc - b_rd), DW'(3));
    chk("t3_ign_writes", DW'(wr_seen - b_wr), DW'(3));
    chk("t3_ign_done_pulses", DW'(done_cnt - b_done), DW'(1));
    chk("t3_ign_sb_empty", DW'(exp_q.size()), '0);

    // len=6 aborted after 3 writes, then a clean len=2 transfer.
    b_wr = wr_seen;
    start_xfer(6, 1'b1);
    n = 0;
    while ((wr_seen - b_wr) < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_three_writes", DW'(wr_seen - b_wr), DW'(3));
    dma_bus.dma_write_ready = 1'b0;
    dma_bus.dma_read_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_done", DW'(done), DW'(1));
    chk("t4_aborted", DW'(aborted), DW'(1));
    chk("t4_req", DW'(dma_bus.dma_req), '0);
    chk("t4_rready", DW'(dma_bus.dma_read_ready), '0);
    chk("t4_wvalid", DW'(dma_bus.dma_write_valid), '0);
    chk("t4_unwritten", DW'(exp_q.size()), DW'(3));
    exp_q.delete();
    @(negedge clk);
    chk("t4_aborted_held", DW'(aborted), DW'(1));
    dma_bus.dma_read_valid = 1'b1;
    dma_bus.dma_write_ready = 1'b1;
    b_wr = wr_seen;
    start_xfer(2, 1'b1);
    wait_done(50, 1'b0);
    chk("t4_next_aborted", DW'(aborted), '0);
    repeat (2) @(negedge clk);
    chk("t4_next_writes", DW'(wr_seen - b_wr), DW'(2));
    chk("t4_next_sb_empty", DW'(exp_q.size()), '0);

    // Reset while the FIFO holds 2 beats.
    dma_bus.dma_write_ready = 1'b0;
    b_rd = rd_acc;
    start_xfer(5, 1'b1);
    n = 0;
    while ((rd_acc - b_rd) < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    dma_bus.dma_read_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_two_reads", DW'(rd_acc - b_rd), DW'(2));
    chk("t5_wvalid_before", DW'(dma_bus.dma_write_valid), DW'(1));
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t5_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dma_bus.dma_read_valid = 1'b1;
    dma_bus.dma_write_ready = 1'b1;
    b_wr = wr_seen;
    start_xfer(1, 1'b1);
    wait_done(50, 1'b0);
    repeat (2) @(negedge clk);
    chk("t5_post_writes", DW'(wr_seen - b_wr), DW'(1));
    chk("t5_post_sb_empty", DW'(exp_q.size()), '0);

    // len=1000 with random valid/ready on both streams.
    b_rd = rd_acc; b_wr = wr_seen; b_done = done_cnt;
    dma_bus.dma_read_valid = 1'($urandom_range(0, 1));
    dma_bus.dma_write_ready = 1'($urandom_range(0, 1));
    start_xfer(1000, 1'b1);
    wait_done(20000, 1'b1);
    dma_bus.dma_read_valid = 1'b0;
    dma_bus.dma_write_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_reads", DW'(rd_acc - b_rd), DW'(1000));
    chk("t6_writes", DW'(wr_seen - b_wr), DW'(1000));
    chk("t6_done_pulses", DW'(done_cnt - b_done), DW'(1));
    chk("t6_sb_empty", DW'(exp_q.size()), '0);
    chk("t6_idle_busy", DW'(busy), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
